// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Bus-side transaction state: idle, or waiting for the response of a fetch / data access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  // Requester that owns the memory bus for the current request.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Consecutive data grants tolerated while a fetch is waiting.
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between the instruction-fetch port
// and the load/store data port. Data has priority, a streak counter bounds
// how long fetch can be starved, and at most one transaction is outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  // instruction-fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory bus
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int STRK_W = $clog2(STARVE_LIMIT + 1);

  state_e              state_q, state_d;
  logic                lock_q, lock_d;
  owner_e              owner_q, owner_d;
  logic [STRK_W-1:0]   d_streak_q, d_streak_d;
  logic                err_q, err_d;

  logic                issue_win;
  logic                req_raw;
  logic                hs;
  logic                streak_full;
  owner_e              sel;

  assign streak_full = (d_streak_q == STRK_W'(STARVE_LIMIT));

  // Selection: a locked owner keeps the bus; otherwise data wins unless fetch has starved long enough.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel       = OWN_D;
    issue_win = (state_q == IDLE) || m_rvalid;
    if (lock_q) begin
      sel = owner_q;
    end else if (d_req && !(i_req && streak_full)) begin
      sel = OWN_D;
    end else if (i_req) begin
      sel = OWN_I;
    end
    req_raw = issue_win && (lock_q || i_req || d_req);
    hs      = req_raw && m_gnt;
  end

  // State register; an abandoned transaction simply returns the bus to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a handshake opens a wait; a response without a new handshake returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (hs) begin
      state_d = (sel == OWN_I) ? WAIT_I : WAIT_D;
    end else if ((state_q != IDLE) && m_rvalid) begin
      state_d = IDLE;
    end
  end

  // Lock, starvation streak and sticky error next values.
  always_comb begin
    lock_d     = lock_q;
    owner_d    = owner_q;
    d_streak_d = d_streak_q;
    if (req_raw && !m_gnt) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end else if (hs) begin
      lock_d = 1'b0;
    end
    if ((hs && (sel == OWN_I)) || !i_req) begin
      d_streak_d = '0;
    end else if (hs && (sel == OWN_D) && !streak_full) begin
      d_streak_d = d_streak_q + STRK_W'(1);
    end
    err_d = err_q || (m_rvalid && (state_q == IDLE)) || (m_gnt && !req_raw);
  end

  // Lock, streak and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      owner_q    <= OWN_I;
      d_streak_q <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      d_streak_q <= d_streak_d;
      err_q      <= err_d;
    end
  end

  // Outputs: combinational bus mux and pass-through grants/responses, all held at 0 during reset.
  always_comb begin
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    err      = 1'b0;
    if (reset) begin
      m_req    = req_raw;
      if (sel == OWN_I) begin
        m_we    = 1'b0;
        m_be    = {BE_W{1'b1}};
        m_addr  = i_addr;
        m_wdata = '0;
      end else begin
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      i_gnt    = hs && (sel == OWN_I);
      d_gnt    = hs && (sel == OWN_D);
      i_rvalid = m_rvalid && (state_q == WAIT_I);
      d_rvalid = m_rvalid && (state_q == WAIT_D);
      i_rdata  = m_rdata;
      d_rdata  = m_rdata;
      err      = err_q;
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level reference
// model (outstanding-response queue, pending owner, starvation count and a
// reference memory image) plus a small memory responder and core drivers.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_gnt, m_rvalid;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          err;
  logic          gnt_ok, gnt_spur;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  // Memory grants combinationally when it is willing; gnt_spur injects a grant with no request.
  assign m_gnt = (m_req & gnt_ok) | gnt_spur;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs
  bit auto_mode;
  bit i_hold, d_hold;
  int i_pct, d_pct, g_pct, lat_min, lat_max;

  // memory responder and core-side bookkeeping
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  bit            env_busy;
  int            env_cnt;
  logic [DW-1:0] env_data;
  bit            i_done, d_done;

  // reference model: kinds 0 = fetch, 1 = load, 2 = store
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            out_kind[$];
  logic [DW-1:0] out_data[$];
  bit            pend_v;
  int            pend_own;
  int            streak;
  bit            exp_err;

  // per-cycle logs for the directed scenarios
  bit            ig_log[$], dg_log[$], irv_log[$], drv_log[$], mreq_log[$], mwe_log[$];
  logic [AW-1:0] addr_log[$];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  task automatic clear_logs();
    ig_log.delete(); dg_log.delete(); irv_log.delete(); drv_log.delete();
    mreq_log.delete(); mwe_log.delete(); addr_log.delete();
  endtask

  task automatic model_reset();
    out_kind.delete(); out_data.delete();
    pend_v = 1'b0; pend_own = 0; streak = 0; exp_err = 1'b0;
  endtask

  // Compare this cycle's outputs against the model, then advance model and environment.
  task automatic monitor();
    bit            win, e_req, e_ig, e_dg, e_irv, e_drv;
    int            own;
    logic [68:0]   e_bus;
    logic [DW-1:0] rd;
    win   = (out_kind.size() == 0) || m_rvalid;
    e_req = win && (pend_v || i_req || d_req);
    if (pend_v) own = pend_own;
    else if (d_req && !(i_req && streak == LIMIT)) own = 1;
    else own = 0;
    e_ig  = e_req && m_gnt && (own == 0);
    e_dg  = e_req && m_gnt && (own == 1);
    e_irv = m_rvalid && (out_kind.size() > 0) && (out_kind[0] == 0);
    e_drv = m_rvalid && (out_kind.size() > 0) && (out_kind[0] != 0);

    n_checks++;
    if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== {e_req, e_ig, e_dg, e_irv, e_drv, exp_err}) begin
      n_fail++;
      $display("FAIL handshake @%0t: got req/ig/dg/irv/drv/err=%b required %b", $time,
               {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err}, {e_req, e_ig, e_dg, e_irv, e_drv, exp_err});
    end
    if (e_req) begin
      e_bus = (own == 1) ? {d_we, d_be, d_addr, d_wdata} : {1'b0, 4'hF, i_addr, 32'h0};
      n_checks++;
      if ({m_we, m_be, m_addr, m_wdata} !== e_bus) begin
        n_fail++;
        $display("FAIL bus_fields @%0t: got %h required %h", $time, {m_we, m_be, m_addr, m_wdata}, e_bus);
      end
    end
    if ((e_irv || e_drv) && out_kind[0] != 2) begin
      rd = e_irv ? i_rdata : d_rdata;
      n_checks++;
      if (rd !== out_data[0]) begin
        n_fail++;
        $display("FAIL rdata @%0t: got %h required %h", $time, rd, out_data[0]);
      end
    end

    ig_log.push_back(i_gnt); dg_log.push_back(d_gnt); irv_log.push_back(i_rvalid);
    drv_log.push_back(d_rvalid); mreq_log.push_back(m_req); mwe_log.push_back(m_we);
    addr_log.push_back(m_addr);

    exp_err = exp_err || (m_rvalid && out_kind.size() == 0) || (m_gnt && !e_req);
    if (m_rvalid && out_kind.size() > 0) begin
      void'(out_kind.pop_front());
      void'(out_data.pop_front());
    end
    if (e_ig) begin
      out_kind.push_back(0); out_data.push_back(ref_rd(i_addr));
    end
    if (e_dg) begin
      if (d_we) begin
        ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_be);
        out_kind.push_back(2); out_data.push_back('0);
      end else begin
        out_kind.push_back(1); out_data.push_back(ref_rd(d_addr));
      end
    end
    if (e_req && !m_gnt) begin
      pend_v = 1'b1; pend_own = own;
    end else if (e_req) begin
      pend_v = 1'b0;
    end
    if (e_ig || !i_req) streak = 0;
    else if (e_dg && streak < LIMIT) streak++;

    i_done = i_gnt;
    d_done = d_gnt;
    if (m_req && m_gnt) begin
      if (m_we) env_mem[m_addr] = merge(env_rd(m_addr), m_wdata, m_be);
      env_data = env_rd(m_addr);
      env_busy = 1'b1;
      env_cnt  = $urandom_range(lat_min, lat_max);
    end
  endtask

  // Drive core requests and memory responses for the next cycle.
  task automatic drive();
    if (auto_mode) begin
      if (i_done || !i_req) begin
        i_req  = ($urandom_range(0, 99) < i_pct);
        i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (d_done || !d_req) begin
        d_req   = ($urandom_range(0, 99) < d_pct);
        d_addr  = 32'($urandom_range(0, 15)) << 2;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(1, 15));
        d_wdata = $urandom;
      end
    end else begin
      if (i_done) begin
        if (i_hold) i_addr = i_addr + 32'd4;
        else i_req = 1'b0;
      end
      if (d_done) begin
        if (d_hold) begin
          d_addr  = d_addr + 32'd4;
          d_we    = 1'($urandom_range(0, 1));
          d_be    = 4'($urandom_range(1, 15));
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end
    end
    i_done = 1'b0;
    d_done = 1'b0;
    gnt_ok = ($urandom_range(0, 99) < g_pct);
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    if (env_busy) begin
      env_cnt--;
      if (env_cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = env_data;
        env_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rvalid = 1'b0; m_rdata = '0; gnt_ok = 1'b0; gnt_spur = 1'b0;
    env_busy = 1'b0; i_done = 1'b0; d_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_manual(input int lat);
    auto_mode = 1'b0; i_hold = 1'b0; d_hold = 1'b0;
    lat_min = lat; lat_max = lat; g_pct = 100; gnt_ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h88;
    d_wdata = 32'h1234_5678; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF; gnt_ok = 1'b1; gnt_spur = 1'b1;
    #3;
    n_checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_be, m_addr, m_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got m_req=%b m_addr=%h i_rdata=%h err=%b required all zero",
               m_req, m_addr, i_rdata, err);
    end
    apply_reset();
    set_manual(1);
    n_checks++;
    if ({m_req, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got m_req/err=%b required 00", {m_req, err});
    end
    repeat (2) cycle();
  endtask

  task automatic test_fetch_stream();
    set_manual(1);
    clear_logs();
    i_req = 1'b1; i_addr = 32'h0; i_hold = 1'b1;
    cycle(); cycle();
    i_hold = 1'b0;
    repeat (3) cycle();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({ig_log[k], irv_log[k]} !== {(k < 3) ? 1'b1 : 1'b0, (k >= 1 && k <= 3) ? 1'b1 : 1'b0}) begin
        n_fail++;
        $display("FAIL fetch_stream cycle %0d: got ig/irv=%b%b", k, ig_log[k], irv_log[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (addr_log[k] !== 32'(k * 4)) begin
        n_fail++;
        $display("FAIL fetch_addr cycle %0d: got %h required %h", k, addr_log[k], k * 4);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_err: got %b required 0", err);
    end
  endtask

  task automatic test_store_then_fetch();
    set_manual(1);
    clear_logs();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h40;
    repeat (4) cycle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({dg_log[k], drv_log[k], ig_log[k], irv_log[k]} !==
          {k == 0, k == 1, k == 1, k == 2}) begin
        n_fail++;
        $display("FAIL store_then_fetch cycle %0d: got dg/drv/ig/irv=%b%b%b%b", k,
                 dg_log[k], drv_log[k], ig_log[k], irv_log[k]);
      end
    end
    n_checks++;
    if ({mwe_log[0], addr_log[0]} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL store_bus: got we=%b addr=%h required we=1 addr=00000100", mwe_log[0], addr_log[0]);
    end
    // fetch the stored word back; the model checks the returned data
    i_req = 1'b1; i_addr = 32'h100;
    repeat (3) cycle();
  endtask

  task automatic test_starvation();
    set_manual(1);
    clear_logs();
    i_req = 1'b1; i_addr = 32'h20; i_hold = 1'b1;
    d_req = 1'b1; d_addr = 32'h180; d_we = 1'b0; d_be = 4'hF; d_hold = 1'b1;
    repeat (15) cycle();
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if ({ig_log[k], dg_log[k]} !== {(k % 5) == 4, (k % 5) != 4}) begin
        n_fail++;
        $display("FAIL starvation cycle %0d: got ig/dg=%b%b required %b%b", k, ig_log[k], dg_log[k],
                 (k % 5) == 4, (k % 5) != 4);
      end
    end
    i_hold = 1'b0; d_hold = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic test_lock();
    set_manual(1);
    clear_logs();
    g_pct = 0; gnt_ok = 1'b0;
    i_req = 1'b1; i_addr = 32'h80;
    cycle();
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF;
    cycle(); cycle();
    g_pct = 100; gnt_ok = 1'b1;
    repeat (4) cycle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({mreq_log[k], addr_log[k], ig_log[k], dg_log[k]} !== {1'b1, 32'h80, k == 3, 1'b0}) begin
        n_fail++;
        $display("FAIL lock_hold cycle %0d: got req=%b addr=%h ig=%b dg=%b required addr 00000080",
                 k, mreq_log[k], addr_log[k], ig_log[k], dg_log[k]);
      end
    end
    n_checks++;
    if ({dg_log[4], addr_log[4], drv_log[5]} !== {1'b1, 32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_then_data: got dg=%b addr=%h drv=%b required 1/00000200/1",
               dg_log[4], addr_log[4], drv_log[5]);
    end
  endtask

  task automatic test_random();
    auto_mode = 1'b1;
    i_pct = 60; d_pct = 60; g_pct = 70; lat_min = 1; lat_max = 3;
    repeat (1500) cycle();
    auto_mode = 1'b0;
  endtask

  task automatic test_err();
    apply_reset();
    set_manual(1);
    cycle();
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_0001;
    cycle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_rvalid_idle: got %b required 1", err);
    end
    repeat (3) cycle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b required 1", err);
    end
    apply_reset();
    set_manual(1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared_by_reset: got %b required 0", err);
    end
    gnt_spur = 1'b1;
    cycle();
    gnt_spur = 1'b0;
    cycle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_gnt_no_req: got %b required 1", err);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_manual(3);
    clear_logs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    cycle();
    #2;
    reset = 1'b0;
    i_req = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_be, m_addr, m_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got m_req=%b m_addr=%h d_rvalid=%b d_rdata=%h required all zero",
               m_req, m_addr, d_rvalid, d_rdata);
    end
    i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
    env_busy = 1'b0; i_done = 1'b0; d_done = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    cycle();
    cycle();
    n_checks++;
    if ({drv_log[0], irv_log[0], err} !== 3'b001) begin
      n_fail++;
      $display("FAIL stale_response: got drv/irv/err=%b%b%b required 001", drv_log[0], irv_log[0], err);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_store_then_fetch();
    test_starvation();
    test_lock();
    test_random();
    test_err();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_mem_port_arbiter
